// File: rtl/logger_mc.sv
// logger_mc: N_CH producers post short text messages. Each message is framed
// with an optional channel tag and line end, queued whole in a byte FIFO, and
// drained to a byte-serial device through a stb/busy handshake. Frames from
// different channels never interleave.

module logger_mc #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = 6,
  parameter int unsigned TAG_EN    = 1,
  parameter int unsigned EOL_EN    = 1,
  parameter int unsigned DROP_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH*MAX_CHARS*8-1:0] ch_text,
  input  logic [N_CH*LEN_W-1:0]       ch_len,
  input  logic [N_CH-1:0]             ch_stb,
  output logic [N_CH-1:0]             ch_busy,
  output logic                        full,
  output logic                        empty,
  output logic [15:0]                 drop_cnt,
  output logic                        ext_stb,
  output logic [7:0]                  ext_data,
  input  logic                        ext_busy
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TW = MAX_CHARS * 8;

  typedef enum logic [2:0] {W_IDLE, W_TAG, W_CHAR, W_EOL, W_DROP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rd_state_e;

  logic [TW-1:0]    hold_text_q [N_CH];
  logic [LEN_W-1:0] hold_len_q  [N_CH];
  logic [N_CH-1:0]  busy_q, busy_d;

  wr_state_e        wr_st_q, wr_st_d;
  rd_state_e        rd_st_q, rd_st_d;
  logic [CW-1:0]    gnt_q, rr_q, grant_c, fin_ch;
  logic             grant_vld;
  logic [LEN_W-1:0] idx_q, cur_len;
  logic [15:0]      drop_cnt_q;
  logic             wr_en, rd_en, fin, drop_pulse;
  logic [7:0]       wr_byte;
  int unsigned      flen_c, space_c;

  logic [7:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, count_c, count_d;
  logic             full_q, empty_q;
  logic [7:0]       ext_data_q;

  // Latch each idle channel's request into its holding register.
  // NOTE: storage arrays carry no reset; busy_q alone says whether an entry is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(N_CH); k++) begin
      if (ch_stb[k] && !busy_q[k]) begin
        hold_text_q[k] <= ch_text[k*TW +: TW];
        hold_len_q[k]  <= (ch_len[k*LEN_W +: LEN_W] > LEN_W'(MAX_CHARS)) ?
                          LEN_W'(MAX_CHARS) : ch_len[k*LEN_W +: LEN_W];
      end
    end
  end

  // A channel turns busy on capture and frees once its frame is finished or dropped.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (fin) busy_d[fin_ch] = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (ch_stb[k] && !busy_q[k]) busy_d[k] = 1'b1;
    end
  end

  // Round-robin pick: first pending channel at or after rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_c   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!grant_vld && busy_q[(int'(rr_q) + i) % int'(N_CH)]) begin
        grant_vld = 1'b1;
        grant_c   = CW'((int'(rr_q) + i) % int'(N_CH));
      end
    end
  end

  assign cur_len = hold_len_q[gnt_q];
  assign count_c = wr_ptr_q - rd_ptr_q;
  assign count_d = count_c + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  assign flen_c  = TAG_EN + EOL_EN + 32'(hold_len_q[grant_c]);
  assign space_c = DEPTH - 32'(count_c);

  // Writer state register plus busy flags.
  // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q <= W_IDLE;
      busy_q  <= '0;
    end else begin
      wr_st_q <= wr_st_d;
      busy_q  <= busy_d;
    end
  end

  // Writer next state: frame is TAG, CHAR x len, EOL, with disabled/empty parts skipped.
  always_comb begin
    wr_st_d = wr_st_q;
    unique case (wr_st_q)
      W_IDLE: if (grant_vld) begin
        if (DROP_MODE != 0 && space_c < flen_c)  wr_st_d = W_DROP;
        else if (TAG_EN != 0)                    wr_st_d = W_TAG;
        else if (hold_len_q[grant_c] != '0)      wr_st_d = W_CHAR;
        else if (EOL_EN != 0)                    wr_st_d = W_EOL;
      end
      W_TAG: if (!full_q) begin
        if (cur_len != '0)    wr_st_d = W_CHAR;
        else if (EOL_EN != 0) wr_st_d = W_EOL;
        else                  wr_st_d = W_IDLE;
      end
      W_CHAR: if (!full_q && idx_q == cur_len - LEN_W'(1)) begin
        wr_st_d = (EOL_EN != 0) ? W_EOL : W_IDLE;
      end
      W_EOL:   if (!full_q) wr_st_d = W_IDLE;
      W_DROP:  wr_st_d = W_IDLE;
      default: wr_st_d = W_IDLE;
    endcase
  end

  // Writer outputs: FIFO write strobe/byte and the frame-finished pulse.
  always_comb begin
    wr_en      = 1'b0;
    wr_byte    = 8'h00;
    fin        = 1'b0;
    fin_ch     = gnt_q;
    drop_pulse = 1'b0;
    unique case (wr_st_q)
      W_IDLE: begin
        // A frame with no bytes at all completes at grant.
        fin    = grant_vld && (flen_c == 0);
        fin_ch = grant_c;
      end
      W_TAG: begin
        wr_en   = !full_q;
        wr_byte = 8'h30 + 8'(gnt_q);
        fin     = !full_q && cur_len == '0 && EOL_EN == 0;
      end
      W_CHAR: begin
        wr_en   = !full_q;
        wr_byte = hold_text_q[gnt_q][(int'(MAX_CHARS) - 1 - int'(idx_q))*8 +: 8];
        fin     = !full_q && idx_q == cur_len - LEN_W'(1) && EOL_EN == 0;
      end
      W_EOL: begin
        wr_en   = !full_q;
        wr_byte = 8'h0A;
        fin     = !full_q;
      end
      W_DROP: begin
        fin        = 1'b1;
        drop_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  // Writer datapath: granted channel, char index, RR pointer, saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_st_q == W_IDLE) begin
        idx_q <= '0;
        if (grant_vld) gnt_q <= grant_c;
      end else if (wr_st_q == W_CHAR && wr_en) begin
        idx_q <= idx_q + LEN_W'(1);
      end
      if (fin) rr_q <= (fin_ch == CW'(N_CH - 1)) ? '0 : fin_ch + CW'(1);
      if (drop_pulse && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_byte;
  end

  // FIFO pointers and flags; flags come from the next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_q <= rd_ptr_q + (AW+1)'(rd_en);
      full_q   <= (count_d == (AW+1)'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Reader state register and output data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st_q    <= R_IDLE;
      ext_data_q <= 8'h00;
    end else begin
      rd_st_q <= rd_st_d;
      if (rd_en) ext_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Reader next state: fetch head, then hold it until the device accepts.
  always_comb begin
    rd_st_d = rd_st_q;
    unique case (rd_st_q)
      R_IDLE:  if (!empty_q) rd_st_d = R_LOAD;
      R_LOAD:  rd_st_d = R_SEND;
      R_SEND:  if (!ext_busy) rd_st_d = empty_q ? R_IDLE : R_LOAD;
      default: rd_st_d = R_IDLE;
    endcase
  end

  // Reader outputs.
  always_comb begin
    rd_en   = (rd_st_q == R_LOAD);
    ext_stb = (rd_st_q == R_SEND);
  end

  assign ch_busy  = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign drop_cnt = drop_cnt_q;
  assign ext_data = ext_data_q;

endmodule
